if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_pkg.sv | 26 ++
 rtl/inst_fifo.sv | 79 +++++++
 rtl/if_prefetch.sv | 128 ++++++++++++
 tb/tb_if_prefetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// if_prefetch_pkg
// Shared pipeline definitions for the instruction-fetch prefetch block:
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - NOP_INST         : instruction word presented when no entry is queued
//   - fetch_state_e    : fetch FSM state encodings
//   - word_align()     : forces an address onto a 32-bit word boundary
// ---------------------------------------------------------------------------
package if_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  // FETCH: normal prefetching.
  // DROP : a read issued before a redirect is still in flight; its data
  //        must be thrown away when it finally returns.
  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// Synchronous FIFO holding {pc, instruction} pairs, oldest first.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push, wdata      : write one entry (ignored when full)
//   pop              : consume head entry (ignored when empty)
//   flush            : discard all entries; wins over push/pop
//   rdata            : head entry (valid when !empty)
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module inst_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  // One register per entry; only the slot addressed by the write pointer loads.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == AW'(gi))) begin
        entry_reg <= wdata;
      end
    end
    assign entry_q[gi] = entry_reg;
  end

  // Head is read straight from the entry registers: a push is visible on the
  // cycle after it is written, with no same-cycle bypass.
  assign rdata = entry_q[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
// Instruction prefetch queue sitting in front of the IF/ID register. Fetches
// sequential words ahead of decode, at most one read outstanding, and throws
// away queued and in-flight instructions on a redirect.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_req, mem_addr          : instruction read request / word address
//   mem_ack, mem_rdata         : read completion / instruction word
//   redirect_valid, redirect_pc: taken branch/jump and its target
//   keep                       : IF/ID stall, holds the head entry
//   inst_valid, inst_pc,
//   inst_pcp4, inst_data       : head entry (zeros / NOP when empty)
// ---------------------------------------------------------------------------
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = if_prefetch_pkg::RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        keep,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pcp4,
  output logic [31:0] inst_data
);

  import if_prefetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  drop_addr_reg, drop_addr_next;
  logic         run_reg;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic [63:0]  fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;

  // run_reg keeps mem_req low for the reset cycle itself while the rest of the
  // request logic stays a pure function of registered state.
  assign mem_req  = run_reg && ((state_reg == DROP) || (fifo_count < CW'(DEPTH)));
  // While dropping, the abandoned read's address must stay on the bus even
  // though fetch_pc already points at the redirect target.
  assign mem_addr = (state_reg == DROP) ? drop_addr_reg : fetch_pc_reg;

  assign fifo_pop = !fifo_empty && !keep && !redirect_valid;

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    drop_addr_next = drop_addr_reg;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;
    case (state_reg)
      FETCH: begin
        if (redirect_valid) begin
          fifo_flush    = 1'b1;
          fetch_pc_next = word_align(redirect_pc);
          if (mem_req && !mem_ack) begin
            state_next     = DROP;
            drop_addr_next = fetch_pc_reg;
          end
        end else if (mem_req && mem_ack && !fifo_full) begin
          fifo_push     = 1'b1;
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          fifo_flush    = 1'b1;
          fetch_pc_next = word_align(redirect_pc);
        end
        if (mem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      fetch_pc_reg  <= word_align(RESET_PC);
      drop_addr_reg <= '0;
      run_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      drop_addr_reg <= drop_addr_next;
      run_reg       <= 1'b1;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_inst_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({mem_addr, mem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = fifo_empty ? 32'h0000_0000 : fifo_rdata[63:32];
  assign inst_pcp4  = fifo_empty ? 32'h0000_0000 : (fifo_rdata[63:32] + 32'd4);
  assign inst_data  = fifo_empty ? NOP_INST : fifo_rdata[31:0];

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        keep;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcp4;
  logic [31:0] inst_data;

  int n_chk;
  int n_err;

  if_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .keep           (keep),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_pcp4      (inst_pcp4),
    .inst_data      (inst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: every word is its own address tagged with KEY.
  assign mem_rdata = mem_addr ^ KEY;

  typedef struct {
    logic        rst;
    logic        keep;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic kp, input logic rv,
                     input logic [31:0] rpc, input logic ack,
                     input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] pc);
    vec_t t;
    t.rst = rst; t.keep = kp; t.rv = rv; t.rpc = rpc; t.ack = ack;
    t.exp_req = req; t.exp_addr = addr; t.exp_valid = v; t.exp_pc = pc;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare all outputs; instruction word and pc+4 follow from the expected pc.
  task automatic chk_outputs(input string tag, input logic req, input logic [31:0] addr,
                             input logic v, input logic [31:0] pc);
    chk({tag, ".mem_req"},    {31'd0, mem_req}, {31'd0, req});
    if (req) chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, ".inst_pc"},    inst_pc,   v ? pc : 32'h0);
    chk({tag, ".inst_pcp4"},  inst_pcp4, v ? pc + 32'd4 : 32'h0);
    chk({tag, ".inst_data"},  inst_data, v ? (pc ^ KEY) : 32'h0);
  endtask

  task automatic drive(input logic rst, input logic kp, input logic rv,
                       input logic [31:0] rpc, input logic ack);
    @(negedge clk);
    reset = rst; keep = kp; redirect_valid = rv; redirect_pc = rpc; mem_ack = ack;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1; keep = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_ack = 1'b1;

    // Sequential fetch from reset, zero-wait memory
    add(0,0,0,32'h0,1, 0,32'h00,0,32'h00);
    add(0,0,0,32'h0,1, 1,32'h00,0,32'h00);
    add(0,0,0,32'h0,1, 1,32'h04,1,32'h00);
    add(0,0,0,32'h0,1, 1,32'h08,1,32'h04);
    add(0,0,0,32'h0,1, 1,32'h0C,1,32'h08);
    // keep held 10 cycles: queue fills to 4 then requests stop
    add(0,1,0,32'h0,1, 1,32'h10,1,32'h0C);
    add(0,1,0,32'h0,1, 1,32'h14,1,32'h0C);
    add(0,1,0,32'h0,1, 1,32'h18,1,32'h0C);
    for (int i = 0; i < 7; i++) add(0,1,0,32'h0,1, 0,32'h1C,1,32'h0C);
    // keep released: no address skipped
    add(0,0,0,32'h0,1, 0,32'h1C,1,32'h0C);
    add(0,0,0,32'h0,1, 1,32'h1C,1,32'h10);
    add(0,0,0,32'h0,1, 1,32'h20,1,32'h14);
    add(0,0,0,32'h0,1, 1,32'h24,1,32'h18);
    add(0,0,0,32'h0,1, 1,32'h28,1,32'h1C);
    add(0,0,0,32'h0,1, 1,32'h2C,1,32'h20);
    // Delayed ack with redirect to 0x100 in the first wait cycle
    add(0,1,1,32'h100,0, 1,32'h30,1,32'h24);
    add(0,0,0,32'h0,0,   1,32'h30,0,32'h00);
    add(0,0,0,32'h0,0,   1,32'h30,0,32'h00);
    add(0,0,0,32'h0,1,   1,32'h30,0,32'h00);
    add(0,0,0,32'h0,1,   1,32'h100,0,32'h00);
    add(0,0,0,32'h0,1,   1,32'h104,1,32'h100);
    add(0,0,0,32'h0,1,   1,32'h108,1,32'h104);
    // Redirect to 0x203 alongside ack and a would-be pop
    add(0,0,1,32'h203,1, 1,32'h10C,1,32'h108);
    add(0,0,0,32'h0,0,   1,32'h200,0,32'h000);
    add(0,0,0,32'h0,1,   1,32'h200,0,32'h000);
    add(0,0,0,32'h0,1,   1,32'h204,1,32'h200);
    // Redirect to the top of the address space, fetch wraps to 0
    add(0,0,1,32'hFFFF_FFFC,1, 1,32'h208,1,32'h204);
    add(0,0,0,32'h0,1,   1,32'hFFFF_FFFC,0,32'h0);
    add(0,0,0,32'h0,1,   1,32'h0000_0000,1,32'hFFFF_FFFC);
    add(0,0,0,32'h0,1,   1,32'h0000_0004,1,32'h0000_0000);
    // Second redirect while already dropping: latest target wins
    add(0,0,0,32'h0,0,   1,32'h008,1,32'h004);
    add(0,0,1,32'h300,0, 1,32'h008,0,32'h000);
    add(0,0,1,32'h404,0, 1,32'h008,0,32'h000);
    add(0,0,0,32'h0,1,   1,32'h008,0,32'h000);
    add(0,0,0,32'h0,1,   1,32'h404,0,32'h000);
    add(0,0,0,32'h0,1,   1,32'h408,1,32'h404);

    // Reset state, with mem_ack high to show it is ignored
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("reset: req=%b valid=%b pc=%h data=%h", mem_req, inst_valid, inst_pc, inst_data);
    chk_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset.mem_addr", mem_addr, 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].keep, vq[i].rv, vq[i].rpc, vq[i].ack);
      $display("vec %0d: keep=%b rv=%b rpc=%h ack=%b -> req=%b addr=%h valid=%b pc=%h",
               i, vq[i].keep, vq[i].rv, vq[i].rpc, vq[i].ack, mem_req, mem_addr, inst_valid, inst_pc);
      chk_outputs($sformatf("vec%0d", i), vq[i].exp_req, vq[i].exp_addr, vq[i].exp_valid, vq[i].exp_pc);
    end

    // Reset while a read is waiting for its ack
    drive(0,1,0,32'h0,0);
    $display("pre-reset wait: req=%b addr=%h valid=%b", mem_req, mem_addr, inst_valid);
    chk_outputs("rst_mid.wait", 1'b1, 32'h40C, 1'b1, 32'h408);
    drive(1,1,0,32'h0,1);
    drive(1,1,0,32'h0,1);
    $display("in reset: req=%b valid=%b pc=%h", mem_req, inst_valid, inst_pc);
    chk_outputs("rst_mid.reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_mid.mem_addr", mem_addr, 32'h0);
    drive(0,0,0,32'h0,1);
    $display("release: req=%b valid=%b", mem_req, inst_valid);
    chk_outputs("rst_mid.release", 1'b0, 32'h0, 1'b0, 32'h0);
    drive(0,0,0,32'h0,1);
    $display("first req: req=%b addr=%h valid=%b", mem_req, mem_addr, inst_valid);
    chk_outputs("rst_mid.first", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(0,0,0,32'h0,1);
    $display("first inst: req=%b addr=%h valid=%b pc=%h", mem_req, mem_addr, inst_valid, inst_pc);
    chk_outputs("rst_mid.inst", 1'b1, 32'h4, 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
